// File: rtl/pipe_pkg.sv
// Shared definitions for the EX/MEM pipeline stage register: FSM encoding,
// default widths and the saturating stall-counter increment.
package pipe_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int STALL_W    = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/pipe_beat_reg.sv
// One beat of storage {we, waddr, wdata}; clear wins over load.
module pipe_beat_reg #(
    parameter int W = 38
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         r_q <= '0;
        else if (i_clear) r_q <= '0;
        else if (i_load)  r_q <= i_d;
    end

    assign o_q = r_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// EX/MEM stage register with valid/ready handshake, optional two-entry skid
// buffer, flush and a saturating downstream-stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int SKID   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_wdata,
    input  logic [ADDR_W-1:0]  in_waddr,
    input  logic               in_we,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_wdata,
    output logic [ADDR_W-1:0]  out_waddr,
    output logic               out_we,
    output logic [STALL_W-1:0] stall_cnt
);
    localparam int BEAT_W = DATA_W + ADDR_W + 1;

    state_e              r_state, w_state_nxt;
    logic                r_in_ready;
    logic [STALL_W-1:0]  r_stall_cnt;
    logic                w_accept, w_drain;
    logic                w_main_load, w_main_clr, w_skid_load, w_skid_clr;
    logic [BEAT_W-1:0]   w_in_beat, w_main_d, w_main_q, w_skid_q;
    logic                w_main_we;
    logic [ADDR_W-1:0]   w_main_waddr;
    logic [DATA_W-1:0]   w_main_wdata;

    assign out_valid = (r_state != ST_EMPTY);
    // Without the skid entry, ready must look through to out_ready; r_in_ready
    // still holds it low until the first edge after reset.
    assign in_ready  = (SKID != 0) ? r_in_ready : (r_in_ready & (~out_valid | out_ready));
    assign w_accept  = in_valid & in_ready & ~flush;
    assign w_drain   = out_valid & out_ready;
    assign w_in_beat = {in_we, in_waddr, in_wdata};

    always_comb begin
        w_state_nxt = r_state;
        w_main_d    = w_in_beat;
        w_main_load = 1'b0;
        w_main_clr  = 1'b0;
        w_skid_load = 1'b0;
        w_skid_clr  = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_clr  = 1'b1;
            w_skid_clr  = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ST_ONE;
                        w_main_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && !w_drain) begin
                        w_state_nxt = ST_FULL;
                        w_skid_load = (SKID != 0);
                    end else if (w_accept && w_drain) begin
                        w_main_load = 1'b1;
                    end else if (w_drain) begin
                        w_state_nxt = ST_EMPTY;
                        w_main_clr  = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (w_drain) begin
                        w_state_nxt = ST_ONE;
                        w_main_d    = w_skid_q;
                        w_main_load = 1'b1;
                        w_skid_clr  = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (SKID != 0) ? (w_state_nxt != ST_FULL) : 1'b1;
            if (out_valid && !out_ready)
                r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

    pipe_beat_reg #(.W(BEAT_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_main_load),
        .i_clear (w_main_clr),
        .i_d     (w_main_d),
        .o_q     (w_main_q)
    );

    pipe_beat_reg #(.W(BEAT_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clr),
        .i_d     (w_in_beat),
        .o_q     (w_skid_q)
    );

    assign {w_main_we, w_main_waddr, w_main_wdata} = w_main_q;

    // Gate by valid so a bubble never writes and never shows stale data.
    assign out_we    = w_main_we & out_valid;
    assign out_waddr = out_valid ? w_main_waddr : '0;
    assign out_wdata = out_valid ? w_main_wdata : '0;
    assign stall_cnt = r_stall_cnt;
endmodule
